hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage core; owns stall, bubble and flush for PC, IF/ID,
//  ID/EX and EX/MEM. Detects load-use hazards between ID/EX and IF/ID, squashes on a taken branch
//  resolved in EX, and freezes the pipe while multicycle data memory is busy.
//  Also keeps stall/flush performance counters and a sticky memory-timeout watchdog.
// PARAMETERS
//  CNT_W     16   width of stall_count / flush_count (saturating)
//  MAX_WAIT  64   consecutive mem_busy cycles before mem_timeout sets (>=1)
// PORTS
//  clk             in   1      core clock, rising edge
//  rst             in   1      asynchronous reset, active-high
//  if_id_rs1       in   5      rs1 field of instruction in IF/ID
//  if_id_rs2       in   5      rs2 field of instruction in IF/ID
//  if_id_use_rs1   in   1      instruction in IF/ID reads rs1
//  if_id_use_rs2   in   1      instruction in IF/ID reads rs2
//  id_ex_MemRead   in   1      instruction in ID/EX is a load
//  id_ex_rd        in   5      destination register of ID/EX
//  branch_taken    in   1      taken branch/jump resolved in EX this cycle
//  mem_busy        in   1      data memory cannot complete MEM-stage access this cycle
//  pc_write        out  1      PC update enable
//  if_id_write     out  1      IF/ID load enable
//  if_id_flush     out  1      IF/ID loads NOP
//  id_ex_bubble    out  1      ID/EX loads zero control (ALUSrc..RegWrite, ALUOp = 0)
//  pipe_hold       out  1      ID/EX, EX/MEM, MEM/WB hold current contents
//  state           out  2      0 RUN, 1 LU_STALL, 2 MEM_WAIT
//  stall_count     out  CNT_W  cycles with pc_write=0 since reset
//  flush_count     out  CNT_W  taken-branch flush events since reset
//  mem_timeout     out  1      sticky: mem_busy held >= MAX_WAIT consecutive cycles
// BEHAVIOUR
//  - Outputs pc_write..pipe_hold combinational (Mealy) from state and inputs; same-cycle effect.
//  - rst high: state=RUN, counters=0, mem_timeout=0, wait counter=0; pc_write=if_id_write=0,
//    if_id_flush=id_ex_bubble=pipe_hold=0 for as long as rst is high.
//  - load_use = id_ex_MemRead & id_ex_rd!=0 &
//    ((if_id_use_rs1 & if_id_rs1==id_ex_rd) | (if_id_use_rs2 & if_id_rs2==id_ex_rd)).
//  - Per-cycle priority: mem_busy > branch_taken > load_use > none.
//    mem_busy:     pipe_hold=1, pc_write=0, if_id_write=0, no flush/bubble; next MEM_WAIT.
//    branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1; flush_count+1; next RUN.
//    load_use:     pc_write=0, if_id_write=0, id_ex_bubble=1; next LU_STALL.
//    none:         pc_write=if_id_write=1, others 0; next RUN.
//  - LU_STALL: lasts exactly one cycle; load_use evaluation suppressed (bubble is in ID/EX);
//    mem_busy and branch_taken still apply with the above priority. Next RUN unless mem_busy.
//  - MEM_WAIT: held while mem_busy=1; on mem_busy=0 same cycle evaluates branch/load_use
//    normally (held EX/ID/EX contents re-present their hazards) and leaves per the table.
//  - Branch + load_use same cycle: flush only, no stall (dependent instr squashed).
//  - stall_count +1 every non-reset cycle with pc_write=0; both counters saturate at all ones.
//  - Wait counter: +1 each mem_busy cycle, cleared when mem_busy=0; reaching MAX_WAIT sets
//    mem_timeout, which stays 1 until rst. Timeout does not alter sequencing.
//  - rst asserted mid-stall or mid-MEM_WAIT aborts immediately to the reset values above.
// TESTING
//  1 id_ex_MemRead=1, id_ex_rd=5, if_id_rs2=5, use_rs2=1 -> 1 cycle pc_write=0, if_id_write=0,
//    id_ex_bubble=1, state->LU_STALL->RUN, stall_count 0->1.
//  2 As 1 but id_ex_rd=0, or use_rs2=0 -> no stall, pc_write=1, stall_count stays 0.
//  3 Load-use and branch_taken same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1,
//    flush_count 0->1, stall_count 0.
//  4 mem_busy 3 cycles during load-use -> pipe_hold=1 for 3 cycles, state MEM_WAIT, then
//    one LU stall cycle; stall_count=4.
//  5 MAX_WAIT=4, mem_busy 5 cycles -> mem_timeout=1 at 4th busy cycle edge, stays 1 after busy drops.
//  6 CNT_W=2, 5 load-use stalls -> stall_count saturates at 3; rst mid-MEM_WAIT -> state 0, counts 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush sequencing for the 5-stage core, with perf counters and memory watchdog.
//   clk, rst                      clock and asynchronous active-high reset
//   if_id_rs1/rs2, use_rs1/rs2    source registers read by the instruction in IF/ID
//   id_ex_MemRead, id_ex_rd       load flag and destination of the instruction in ID/EX
//   branch_taken, mem_busy        taken branch resolved in EX; data memory not ready
//   pc_write, if_id_write         PC and IF/ID load enables
//   if_id_flush, id_ex_bubble     squash IF/ID to NOP; zero ID/EX control
//   pipe_hold                     freeze ID/EX, EX/MEM, MEM/WB
//   state                         0 RUN, 1 LU_STALL, 2 MEM_WAIT
//   stall_count, flush_count      saturating counts of stalled cycles and branch flushes
//   mem_timeout                   sticky: mem_busy held for MAX_WAIT consecutive cycles
module hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_use_rs1,
    input  logic             if_id_use_rs2,
    input  logic             id_ex_MemRead,
    input  logic [4:0]       id_ex_rd,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);
    typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    state_t cur, nxt;
    logic load_use;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    assign state = cur;
    assign load_use = id_ex_MemRead && id_ex_rd != 5'd0 &&
        ((if_id_use_rs1 && if_id_rs1 == id_ex_rd) || (if_id_use_rs2 && if_id_rs2 == id_ex_rd));
    // Wait counter saturates at MAX_WAIT so it can never wrap back below the threshold.
    assign wait_nxt = !mem_busy ? '0 : (wait_cnt == WAIT_W'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;
        nxt          = RUN;
        if (rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (mem_busy) begin
            pipe_hold   = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            nxt         = MEM_WAIT;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use && cur != LU_STALL) begin
            // In LU_STALL the load has moved on and a bubble sits in ID/EX, so no re-stall.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            nxt          = LU_STALL;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            cur         <= nxt;
            wait_cnt    <= wait_nxt;
            mem_timeout <= mem_timeout || wait_nxt == WAIT_W'(MAX_WAIT);
            stall_count <= (!pc_write && stall_count != '1) ? stall_count + 1'b1 : stall_count;
            flush_count <= (if_id_flush && flush_count != '1) ? flush_count + 1'b1 : flush_count;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl; dut_a (CNT_W=16, MAX_WAIT=4), dut_b (CNT_W=2, MAX_WAIT=64).
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] rs1, rs2, rd;
    logic use1, use2, mrd, br, busy;
    logic a_pc, a_ifw, a_fl, a_bub, a_hold, a_to;
    logic [1:0] a_st;
    logic [15:0] a_sc, a_fc;
    logic b_pc, b_ifw, b_fl, b_bub, b_hold, b_to;
    logic [1:0] b_st;
    logic [1:0] b_sc, b_fc;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16), .MAX_WAIT(4)) dut_a (
        .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_use_rs1(use1),
        .if_id_use_rs2(use2), .id_ex_MemRead(mrd), .id_ex_rd(rd), .branch_taken(br),
        .mem_busy(busy), .pc_write(a_pc), .if_id_write(a_ifw), .if_id_flush(a_fl),
        .id_ex_bubble(a_bub), .pipe_hold(a_hold), .state(a_st), .stall_count(a_sc),
        .flush_count(a_fc), .mem_timeout(a_to));

    hazard_ctrl #(.CNT_W(2), .MAX_WAIT(64)) dut_b (
        .clk(clk), .rst(rst), .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_use_rs1(use1),
        .if_id_use_rs2(use2), .id_ex_MemRead(mrd), .id_ex_rd(rd), .branch_taken(br),
        .mem_busy(busy), .pc_write(b_pc), .if_id_write(b_ifw), .if_id_flush(b_fl),
        .id_ex_bubble(b_bub), .pipe_hold(b_hold), .state(b_st), .stall_count(b_sc),
        .flush_count(b_fc), .mem_timeout(b_to));

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; use1 = 1'b0; use2 = 1'b0;
        mrd = 1'b0; br = 1'b0; busy = 1'b0;
    endtask

    task automatic lu_inputs();
        mrd = 1'b1; rd = 5'd5; rs2 = 5'd5; use2 = 1'b1; rs1 = 5'd3; use1 = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        lu_inputs();
        busy = 1'b1;
        br = 1'b1;
        rst = 1'b1;
        tick();
        total++; if (a_pc !== 1'b0 || a_ifw !== 1'b0) $display("FAIL reset_enables got pc=%0b ifw=%0b exp 0 0", a_pc, a_ifw); else passed++;
        total++; if ({a_fl, a_bub, a_hold} !== 3'b000) $display("FAIL reset_ctl got %03b exp 000", {a_fl, a_bub, a_hold}); else passed++;
        total++; if (a_st !== 2'd0 || a_sc !== 16'd0 || a_fc !== 16'd0 || a_to !== 1'b0)
            $display("FAIL reset_regs got st=%0d sc=%0d fc=%0d to=%0b exp 0 0 0 0", a_st, a_sc, a_fc, a_to); else passed++;
        do_reset();
        total++; if (a_pc !== 1'b1 || a_ifw !== 1'b1) $display("FAIL reset_release got pc=%0b ifw=%0b exp 1 1", a_pc, a_ifw); else passed++;
    endtask

    task automatic test_load_use();
        do_reset();
        lu_inputs();
        #1;
        total++; if ({a_pc, a_ifw, a_bub, a_fl, a_hold} !== 5'b00100)
            $display("FAIL lu_outputs got %05b exp 00100", {a_pc, a_ifw, a_bub, a_fl, a_hold}); else passed++;
        tick();
        total++; if (a_st !== 2'd1 || a_sc !== 16'd1) $display("FAIL lu_state got st=%0d sc=%0d exp 1 1", a_st, a_sc); else passed++;
        total++; if ({a_pc, a_ifw, a_bub} !== 3'b110) $display("FAIL lu_stall_cycle got %03b exp 110", {a_pc, a_ifw, a_bub}); else passed++;
        tick();
        total++; if (a_st !== 2'd0 || a_sc !== 16'd1) $display("FAIL lu_return got st=%0d sc=%0d exp 0 1", a_st, a_sc); else passed++;
    endtask

    task automatic test_no_hazard();
        do_reset();
        lu_inputs();
        rd = 5'd0; rs2 = 5'd0; rs1 = 5'd0;
        #1;
        total++; if (a_pc !== 1'b1 || a_bub !== 1'b0) $display("FAIL rd0 got pc=%0b bub=%0b exp 1 0", a_pc, a_bub); else passed++;
        tick();
        lu_inputs();
        use2 = 1'b0;
        #1;
        total++; if (a_pc !== 1'b1 || a_bub !== 1'b0) $display("FAIL norm_use2 got pc=%0b bub=%0b exp 1 0", a_pc, a_bub); else passed++;
        tick();
        total++; if (a_sc !== 16'd0 || a_st !== 2'd0) $display("FAIL nohaz_count got sc=%0d st=%0d exp 0 0", a_sc, a_st); else passed++;
        rs1 = 5'd5;
        #1;
        total++; if (a_pc !== 1'b0 || a_bub !== 1'b1) $display("FAIL rs1_match got pc=%0b bub=%0b exp 0 1", a_pc, a_bub); else passed++;
    endtask

    task automatic test_branch();
        do_reset();
        lu_inputs();
        br = 1'b1;
        #1;
        total++; if ({a_pc, a_ifw, a_fl, a_bub, a_hold} !== 5'b11110)
            $display("FAIL br_lu_outputs got %05b exp 11110", {a_pc, a_ifw, a_fl, a_bub, a_hold}); else passed++;
        tick();
        total++; if (a_fc !== 16'd1 || a_sc !== 16'd0 || a_st !== 2'd0)
            $display("FAIL br_counts got fc=%0d sc=%0d st=%0d exp 1 0 0", a_fc, a_sc, a_st); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        br = 1'b1;
        tick();
        tick();
        br = 1'b0;
        tick();
        total++; if (a_fc !== 16'd2 || b_fc !== 2'd2) $display("FAIL b2b_flush got a=%0d b=%0d exp 2 2", a_fc, b_fc); else passed++;
        busy = 1'b1;
        tick();
        busy = 1'b0;
        br = 1'b1;
        #1;
        total++; if ({a_pc, a_fl, a_bub, a_hold} !== 4'b1110) $display("FAIL memwait_branch got %04b exp 1110", {a_pc, a_fl, a_bub, a_hold}); else passed++;
        tick();
        total++; if (a_st !== 2'd0 || a_fc !== 16'd3) $display("FAIL memwait_branch_exit got st=%0d fc=%0d exp 0 3", a_st, a_fc); else passed++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        lu_inputs();
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if ({a_hold, a_pc, a_ifw, a_bub, a_fl} !== 5'b10000)
                $display("FAIL mw_cycle%0d got %05b exp 10000", i, {a_hold, a_pc, a_ifw, a_bub, a_fl}); else passed++;
            tick();
            total++; if (a_st !== 2'd2) $display("FAIL mw_state%0d got %0d exp 2", i, a_st); else passed++;
        end
        busy = 1'b0;
        #1;
        total++; if ({a_hold, a_pc, a_bub} !== 3'b001) $display("FAIL mw_exit_lu got %03b exp 001", {a_hold, a_pc, a_bub}); else passed++;
        tick();
        total++; if (a_st !== 2'd1 || a_sc !== 16'd4 || b_sc !== 2'd3)
            $display("FAIL mw_lu_state got st=%0d sc=%0d bsc=%0d exp 1 4 3", a_st, a_sc, b_sc); else passed++;
        tick();
        total++; if (a_st !== 2'd0 || a_sc !== 16'd4 || a_to !== 1'b0)
            $display("FAIL mw_done got st=%0d sc=%0d to=%0b exp 0 4 0", a_st, a_sc, a_to); else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        busy = 1'b1;
        tick(); tick(); tick();
        busy = 1'b0;
        tick();
        busy = 1'b1;
        tick(); tick(); tick();
        total++; if (a_to !== 1'b0) $display("FAIL to_nonconsec got %0b exp 0", a_to); else passed++;
        busy = 1'b0;
        tick();
        busy = 1'b1;
        tick(); tick(); tick();
        total++; if (a_to !== 1'b0) $display("FAIL to_three got %0b exp 0", a_to); else passed++;
        tick();
        total++; if (a_to !== 1'b1) $display("FAIL to_fourth got %0b exp 1", a_to); else passed++;
        tick();
        busy = 1'b0;
        tick(); tick();
        total++; if (a_to !== 1'b1 || b_to !== 1'b0 || a_st !== 2'd0)
            $display("FAIL to_sticky got a=%0b b=%0b st=%0d exp 1 0 0", a_to, b_to, a_st); else passed++;
    endtask

    task automatic test_saturate();
        do_reset();
        lu_inputs();
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
        end
        total++; if (b_sc !== 2'd3 || a_sc !== 16'd5) $display("FAIL sat_stall got b=%0d a=%0d exp 3 5", b_sc, a_sc); else passed++;
        idle();
        busy = 1'b1;
        tick();
        total++; if (a_st !== 2'd2) $display("FAIL sat_memwait got %0d exp 2", a_st); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (a_st !== 2'd0 || a_sc !== 16'd0 || b_sc !== 2'd0 || a_hold !== 1'b0 || a_pc !== 1'b0)
            $display("FAIL async_rst got st=%0d sc=%0d bsc=%0d hold=%0b pc=%0b exp 0 0 0 0 0", a_st, a_sc, b_sc, a_hold, a_pc); else passed++;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_back_to_back();
        test_mem_wait();
        test_timeout();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
